store_align_buffer: RTL and testbench

//   Store-side counterpart of the load extension unit. Takes a store (SB/SH/SW) from the MEM stage and checks alignment.

---
 rtl/store_align_buffer.sv | 115 +++++++++++
 tb/tb_store_align_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_align_buffer.sv
// rtl/store_align_buffer.sv - store alignment check, byte-lane encode and in-order write buffer
//
// Purpose: accepts SB/SH/SW stores from MEM and flags misaligned ones (AdES).
//   Aligned stores become word-address / lane-replicated data / byte-strobe
//   entries in a small FIFO, which drains to data memory over a req/ack handshake.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   st_valid/st_ready               store handshake (st_ready = !full)
//   st_type, st_addr, st_data       store size, byte address, rt value
//   st_ade, st_badvaddr             misaligned pulse and captured address
//   mem_req/mem_ack                 drain handshake for the head entry
//   mem_addr, mem_wdata, mem_wstrb  head entry, zero while empty
//   buf_empty, buf_count            occupancy
module store_align_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [1:0]       st_type,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    output logic             st_ade,
    output logic [31:0]      st_badvaddr,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ack,
    output logic             buf_empty,
    output logic [CNT_W-1:0] buf_count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      q_addr  [DEPTH];
    logic [31:0]      q_wdata [DEPTH];
    logic [3:0]       q_wstrb [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic        accept;
    logic        misaligned;
    logic        push;
    logic        pop;
    logic [3:0]  enc_strb;
    logic [31:0] enc_data;

    assign st_ready  = (count != CNT_W'(DEPTH));
    assign accept    = st_valid && st_ready;
    assign buf_empty = (count == '0);
    assign buf_count = count;
    assign mem_req   = !buf_empty;

    // A misaligned store still completes its handshake but never enters the queue.
    assign push = accept && !misaligned;
    assign pop  = mem_req && mem_ack;

    always_comb begin
        misaligned = 1'b0;
        enc_strb   = 4'b1111;
        enc_data   = st_data;
        case (st_type)
            2'b00: begin
                enc_strb = 4'b0001 << st_addr[1:0];
                enc_data = {4{st_data[7:0]}};
            end
            2'b01: begin
                misaligned = st_addr[0];
                enc_strb   = st_addr[1] ? 4'b1100 : 4'b0011;
                enc_data   = {2{st_data[15:0]}};
            end
            default: begin
                // 2'b11 is handled as SW
                misaligned = (st_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Entry storage is only meaningful behind count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= {st_addr[31:2], 2'b00};
            q_wdata[wr_ptr] <= enc_data;
            q_wstrb[wr_ptr] <= enc_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            st_ade      <= 1'b0;
            st_badvaddr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            st_ade <= accept && misaligned;
            if (accept && misaligned) st_badvaddr <= st_addr;
        end
    end

    // Head fields are forced to zero when nothing is pending so stale data never shows.
    assign mem_addr  = mem_req ? q_addr[rd_ptr]  : 32'd0;
    assign mem_wdata = mem_req ? q_wdata[rd_ptr] : 32'd0;
    assign mem_wstrb = mem_req ? q_wstrb[rd_ptr] : 4'd0;
endmodule

// File: tb/tb_store_align_buffer.sv
// tb/tb_store_align_buffer.sv - directed table-driven bench for store_align_buffer
module tb_store_align_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [1:0]  st_type = 2'b00;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ade;
    logic [31:0] st_badvaddr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack = 1'b0;
    logic        buf_empty;
    logic [2:0]  buf_count;

    int total = 0;
    int bad = 0;

    store_align_buffer #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_type(st_type),
        .st_addr(st_addr), .st_data(st_data),
        .st_ade(st_ade), .st_badvaddr(st_badvaddr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .buf_empty(buf_empty), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        eade;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic [3:0]  estrb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_type  = t;
        st_addr  = a;
        st_data  = d;
    endtask

    initial begin
        vecs[0]  = '{2'b00, 32'h0000_1003, 32'h1234_5678, 1'b0, 32'h0000_1000, 32'h7878_7878, 4'b1000};
        vecs[1]  = '{2'b00, 32'h0000_1000, 32'hAABB_CCDD, 1'b0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b0001};
        vecs[2]  = '{2'b00, 32'h0000_1001, 32'h0000_0042, 1'b0, 32'h0000_1000, 32'h4242_4242, 4'b0010};
        vecs[3]  = '{2'b00, 32'h0000_1006, 32'h0000_00A5, 1'b0, 32'h0000_1004, 32'hA5A5_A5A5, 4'b0100};
        vecs[4]  = '{2'b01, 32'h0000_2002, 32'hAAAA_5678, 1'b0, 32'h0000_2000, 32'h5678_5678, 4'b1100};
        vecs[5]  = '{2'b01, 32'h0000_2000, 32'h1234_BEEF, 1'b0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011};
        vecs[6]  = '{2'b10, 32'h0000_2004, 32'hCAFE_F00D, 1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'b1111};
        vecs[7]  = '{2'b11, 32'h0000_2008, 32'h0102_0304, 1'b0, 32'h0000_2008, 32'h0102_0304, 4'b1111};
        vecs[8]  = '{2'b01, 32'h0000_2001, 32'h1111_2222, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[9]  = '{2'b01, 32'h0000_2003, 32'h3333_4444, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[10] = '{2'b10, 32'h0000_2006, 32'h5555_6666, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[11] = '{2'b11, 32'h0000_2009, 32'h7777_8888, 1'b1, 32'h0, 32'h0, 4'b0000};

        // Reset state
        #12;
        chk("rst_count", 32'(buf_count), 32'd0);
        chk("rst_empty", 32'(buf_empty), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_ade", 32'(st_ade), 32'd0);
        chk("rst_badvaddr", st_badvaddr, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_ready", 32'(st_ready), 32'd1);
        rst = 1'b0;
        step();

        // Single-store encoding table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].typ, vecs[i].addr, vecs[i].data);
            step();
            st_valid = 1'b0;
            if (vecs[i].eade) begin
                chk($sformatf("v%0d_ade", i), 32'(st_ade), 32'd1);
                chk($sformatf("v%0d_badvaddr", i), st_badvaddr, vecs[i].addr);
                chk($sformatf("v%0d_req", i), 32'(mem_req), 32'd0);
                chk($sformatf("v%0d_count", i), 32'(buf_count), 32'd0);
                step();
                chk($sformatf("v%0d_ade_pulse", i), 32'(st_ade), 32'd0);
                chk($sformatf("v%0d_badvaddr_hold", i), st_badvaddr, vecs[i].addr);
                chk($sformatf("v%0d_req_after", i), 32'(mem_req), 32'd0);
            end else begin
                chk($sformatf("v%0d_ade", i), 32'(st_ade), 32'd0);
                chk($sformatf("v%0d_req", i), 32'(mem_req), 32'd1);
                chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].eaddr);
                chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].edata);
                chk($sformatf("v%0d_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].estrb));
                step();
                chk($sformatf("v%0d_hold_addr", i), mem_addr, vecs[i].eaddr);
                mem_ack = 1'b1;
                step();
                mem_ack = 1'b0;
                chk($sformatf("v%0d_empty", i), 32'(buf_empty), 32'd1);
            end
        end

        // Ordering: SH then SW
        drive(2'b01, 32'h0000_2002, 32'hAAAA_5678);
        step();
        drive(2'b10, 32'h0000_2004, 32'h0BAD_CAFE);
        step();
        st_valid = 1'b0;
        chk("ord_count", 32'(buf_count), 32'd2);
        chk("ord_h0_strb", 32'(mem_wstrb), 32'b1100);
        chk("ord_h0_data", mem_wdata, 32'h5678_5678);
        mem_ack = 1'b1;
        step();
        chk("ord_h1_addr", mem_addr, 32'h0000_2004);
        chk("ord_h1_strb", 32'(mem_wstrb), 32'b1111);
        chk("ord_h1_data", mem_wdata, 32'h0BAD_CAFE);
        step();
        mem_ack = 1'b0;
        chk("ord_empty", 32'(buf_empty), 32'd1);

        // mem_ack while empty is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_count", 32'(buf_count), 32'd0);

        // Full, held-off 5th store, drain in order
        for (int k = 0; k < 4; k++) begin
            drive(2'b10, 32'h0000_0100 + 32'(4 * k), 32'(k));
            step();
        end
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_count", 32'(buf_count), 32'd4);
        drive(2'b10, 32'h0000_0110, 32'd4);
        step();
        step();
        chk("full_held_count", 32'(buf_count), 32'd4);
        chk("full_held_head", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("pop_ready", 32'(st_ready), 32'd1);
        chk("pop_count", 32'(buf_count), 32'd3);
        step();
        st_valid = 1'b0;
        chk("refill_count", 32'(buf_count), 32'd4);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("drain%0d_addr", k), mem_addr, 32'h0000_0100 + 32'(4 * k));
            chk($sformatf("drain%0d_data", k), mem_wdata, 32'(k));
            mem_ack = 1'b1;
            step();
            mem_ack = 1'b0;
        end
        chk("drain_empty", 32'(buf_empty), 32'd1);

        // Streaming: one store per cycle with continuous ack
        mem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(2'b00, 32'h0000_0300 + 32'(4 * k), 32'(k));
            step();
            chk($sformatf("stream%0d_count", k), 32'(buf_count), 32'd1);
            chk($sformatf("stream%0d_addr", k), mem_addr, 32'h0000_0300 + 32'(4 * k));
        end
        st_valid = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("stream_empty", 32'(buf_empty), 32'd1);

        // Asynchronous reset with two stores pending
        drive(2'b10, 32'h0000_0400, 32'h1);
        step();
        drive(2'b10, 32'h0000_0404, 32'h2);
        step();
        st_valid = 1'b0;
        chk("pre_rst_count", 32'(buf_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_count", 32'(buf_count), 32'd0);
        #1;
        rst = 1'b0;
        step();
        drive(2'b00, 32'h0000_0502, 32'h0000_00C3);
        step();
        st_valid = 1'b0;
        chk("post_rst_req", 32'(mem_req), 32'd1);
        chk("post_rst_addr", mem_addr, 32'h0000_0500);
        chk("post_rst_strb", 32'(mem_wstrb), 32'b0100);
        chk("post_rst_data", mem_wdata, 32'hC3C3_C3C3);
        chk("post_rst_count", 32'(buf_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
